latency_ram: RTL
================

# latency_ram

Word-addressed, single-port RAM model with a programmable access latency. It sits directly downstream of the CPU's `cpu_ram_if.cpu` port and consumes `memaddr`, `memstore`, `memREN` and `memWEN`. It returns `ramload` and `ramstate` to the memory controller. It emulates a slow main memory with a request/wait/access handshake, so that cache and memory-controller stall logic is exercised with realistic, parameterised delay.

## Interface
- `LAT`, default 2: number of BUSY cycles inserted before ACCESS; legal range 0–15.
- `ADDR_BITS`, default 14: log2 of the number of 32-bit words stored; the array is 2^ADDR_BITS words.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `memaddr`  in  32  byte address of the request; word index is `memaddr[ADDR_BITS+1:2]`.
- `memstore`  in  32  write data.
- `memREN`  in  1  read request; held by the requester until ACCESS.
- `memWEN`  in  1  write request; held by the requester until ACCESS.
- `ramload`  out  32  read data; registered.
- `ramstate`  out  2  encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; decoded from state only, never from inputs.

## Operation
- Internal state registers:
  - FSM states: IDLE, WAIT, DONE, ERR.
  - Latched request: `op` (read/write), `addr`, `wdata`.
  - 4-bit down-counter `cnt`.
- `ramstate` by state: IDLE→FREE, WAIT→BUSY, DONE→ACCESS, ERR→ERROR.
- A request is valid when exactly one of REN/WEN is high, `memaddr[1:0]==0`, and `memaddr[31:ADDR_BITS+2]==0`.
- IDLE behaviour:
  - No request: stay in IDLE.
  - Valid request: latch op, address and data, then:
    - if LAT==0, go to DONE;
    - otherwise load `cnt<=LAT-1` and go to WAIT.
  - REN and WEN both high, misaligned address, or out-of-range address: go to ERR.
- WAIT behaviour:
  - Abort: if both REN and WEN are low, or if `memaddr`/op differ from the latched values, return to IDLE. No write occurs and `ramload` is unchanged.
  - Otherwise, if `cnt==0`, go to DONE; else decrement `cnt`.
- Entering DONE:
  - Read: `ramload <= mem[addr]`.
  - Write: `ramload` unchanged.
- Leaving DONE:
  - Write: `mem[addr] <= wdata` commits on this edge.
  - DONE lasts exactly one cycle, then always goes to IDLE.
  - Write data is the value latched at request acceptance; later `memstore` changes are ignored.
- ERR lasts one cycle, then goes to IDLE. No memory change; `ramload` unchanged.
- A request still asserted after ACCESS or ERROR is treated as a new request in the following IDLE cycle. Requesters must deassert or change the request in the ACCESS cycle.
- Array contents are not affected by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, `ramstate`=FREE, `ramload`=0, `cnt`=0, latched request cleared.
- Reset asserted mid-transaction discards the transaction; a pending write never commits.
- Latency: a request first sampled in IDLE at cycle 0 produces ACCESS in cycle LAT+1. `ramload` is valid throughout that cycle.
- Throughput: each transaction occupies LAT+2 cycles including the mandatory IDLE cycle, so back-to-back requests are spaced LAT+2 cycles apart.
- Read-after-write to the same word: the write commits on the edge ending its ACCESS cycle. A following read (accepted one cycle later at the earliest) returns the new data.
- ERROR appears exactly one cycle after an illegal request is sampled.
- `cnt` underflow is impossible: the WAIT→DONE transition is taken at `cnt==0`.

## Test plan
- Reset values: assert `nRST` low mid-WAIT of a write to 0x40 (data 0xDEADBEEF). Required:
  - `ramstate`=FREE and `ramload`=0 immediately;
  - after release, a read of 0x40 does not return 0xDEADBEEF (previously written 0x11111111 is still there).
- Write then read, LAT=2: write 0x12345678 to 0x100, then read 0x100. Required:
  - each transaction shows `ramstate` FREE,BUSY,BUSY,ACCESS;
  - `ramload`=0x12345678 in the read's ACCESS cycle;
  - second request accepted 4 cycles after the first.
- LAT=0 build: read of 0x8 after writing 0xA5A5A5A5. Required: ACCESS in the cycle after request, `ramload`=0xA5A5A5A5.
- Abort: start a write of 0xCAFEF00D to 0x200, then change `memaddr` to 0x204 in the first BUSY cycle. Required:
  - return to FREE;
  - the new request restarts the full latency;
  - 0x200 retains its old value, 0x204 gets 0xCAFEF00D.
- Errors: REN=WEN=1 at 0x0; read of 0x3; read of 0x0001_0000 with ADDR_BITS=14. Required for each:
  - `ramstate`=ERROR for exactly one cycle, then FREE;
  - no memory change;
  - `ramload` unchanged.
- Held request: keep REN high at 0x10 across 3 transactions. Required: ACCESS pulses every LAT+2 cycles, each exactly one cycle wide.

Source files
------------

// File: rtl/latency_ram.sv
// Single-port word-addressed RAM that emulates slow main memory: each request
// waits LAT BUSY cycles, then gets one ACCESS cycle, with abort and error handling.
module latency_ram #(
    parameter int unsigned LAT       = 2,
    parameter int unsigned ADDR_BITS = 14
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    localparam int unsigned WORDS    = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_INIT = 4'((LAT == 0) ? 0 : LAT - 1);

    logic [31:0] mem [WORDS];

    state_t                 state_q, state_d;
    logic                   op_q, op_d;          // 1 = write, 0 = read
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [31:0]            ramload_q, ramload_d;

    logic [ADDR_BITS-1:0]   req_idx;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic                   req_any;
    logic                   req_valid;
    logic                   same_req;
    logic                   load_rd;

    always_comb begin
        req_idx   = memaddr[ADDR_BITS+1:2];
        req_any   = memREN | memWEN;
        req_valid = (memREN ^ memWEN) && (memaddr[1:0] == 2'b00)
                    && ((memaddr >> (ADDR_BITS + 2)) == 32'd0);
        // A WAIT request survives only if the requester still presents the
        // exact address and operation that was accepted.
        same_req  = (memaddr == (32'(addr_q) << 2))
                    && (op_q ? (memWEN && !memREN) : (memREN && !memWEN));
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ramload_d = ramload_q;
        load_rd   = 1'b0;
        rd_idx    = addr_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (req_valid) begin
                        op_d    = memWEN;
                        addr_d  = req_idx;
                        wdata_d = memstore;
                        if (LAT == 0) begin
                            state_d = DONE;
                            load_rd = !memWEN;
                            rd_idx  = req_idx;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = WAIT;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                if (!same_req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    load_rd = !op_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load_rd) begin
            ramload_d = mem[rd_idx];
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    ramstate = 2'd0;
            WAIT:    ramstate = 2'd1;
            DONE:    ramstate = 2'd2;
            default: ramstate = 2'd3;
        endcase
    end

    assign ramload = ramload_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 4'd0;
            ramload_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            ramload_q <= ramload_d;
        end
    end

    // Writes commit on the edge that leaves ACCESS; the array is never reset.
    always_ff @(posedge CLK) begin
        if (state_q == DONE && op_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
